// File: rtl/orion_mem_pkg.sv
// Shared types for the single-port RAM request path: access sizes, the
// request record, byte-lane constants and the alignment rule.
package orion_mem_pkg;

  // Number of byte lanes in one RAM word and the width of a lane index.
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = $clog2(NUM_LANES);

  // Access size as encoded on the request port.
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2,
    MEM_RSVD = 2'd3
  } mem_size_e;

  // One byte-addressed request as seen on the core side. "zext" selects
  // zero extension of narrow loads ("unsigned" is a reserved word).
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    mem_size_e   size;
    logic        zext;
    logic [31:0] wdata;
  } mem_req_t;

  // Adapter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } adapter_state_e;

  // A half must sit on an even byte, a word on a multiple of four.
  function automatic logic is_misaligned(mem_size_e size, logic [LANE_W-1:0] lane);
    case (size)
      MEM_HALF: return lane[0];
      MEM_WORD: return |lane;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for the RAM adapter: builds byte mask and
// replicated write data for an incoming request, flags illegal requests,
// and extracts/extends load data from a RAM word.
module mem_align
  import orion_mem_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  mem_req_t              req,
  output logic [NUM_LANES-1:0]  mask,
  output logic [31:0]           wdata,
  output logic                  fault,
  input  logic [LANE_W-1:0]     ld_lane,
  input  mem_size_e             ld_size,
  input  logic                  ld_zext,
  input  logic [31:0]           ld_raw,
  output logic [31:0]           ld_data
);

  logic [LANE_W-1:0] lane;
  logic [31:0]       shifted;
  logic              ext_bit;

  assign lane = req.addr[LANE_W-1:0];

  // Store path: the RAM writes only masked lanes, so the data is simply
  // replicated across the word and the mask picks the addressed lanes.
  always_comb begin
    mask  = '0;
    wdata = '0;
    case (req.size)
      MEM_BYTE: begin
        mask  = 4'b0001 << lane;
        wdata = {4{req.wdata[7:0]}};
      end
      MEM_HALF: begin
        mask  = 4'b0011 << lane;
        wdata = {2{req.wdata[15:0]}};
      end
      MEM_WORD: begin
        mask  = 4'b1111;
        wdata = req.wdata;
      end
      default: begin
        mask  = '0;
        wdata = '0;
      end
    endcase
    if (!req.we) begin
      wdata = '0;
    end
  end

  // Fault detection: reserved size, misalignment or an address past the RAM.
  always_comb begin
    fault = (req.size == MEM_RSVD) ||
            is_misaligned(req.size, lane) ||
            (req.addr >= 32'(SIZE));
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = ld_raw >> {ld_lane, 3'b000};
    ext_bit = 1'b0;
    ld_data = shifted;
    case (ld_size)
      MEM_BYTE: begin
        ext_bit = ~ld_zext & shifted[7];
        ld_data = {{24{ext_bit}}, shifted[7:0]};
      end
      MEM_HALF: begin
        ext_bit = ~ld_zext & shifted[15];
        ld_data = {{16{ext_bit}}, shifted[15:0]};
      end
      default: begin
        ext_bit = 1'b0;
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/spram_req_adapter.sv
// Request-side front end for the single-port RAM. Takes one byte-addressed
// load/store at a time, faults illegal requests without touching memory,
// strobes the RAM for one cycle, waits for its response and returns the
// aligned, extended result under response backpressure.
module spram_req_adapter
  import orion_mem_pkg::*;
#(
  parameter int SIZE      = 1024,
  parameter int DATAW     = 32,
  parameter int MEM_ADDRW = $clog2(SIZE)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [31:0]          req_addr_i,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [DATAW-1:0]     req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAW-1:0]     rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [MEM_ADDRW-1:0] mem_addr_o,
  output logic [DATAW-1:0]     mem_data_o,
  output logic [NUM_LANES-1:0] mem_mask_o,
  output logic                 mem_we_o,
  output logic                 mem_valid_o,
  input  logic [DATAW-1:0]     mem_data_i,
  input  logic                 mem_resp_i
);

  adapter_state_e        state;
  mem_req_t              in_req;
  logic [NUM_LANES-1:0]  st_mask;
  logic [DATAW-1:0]      st_wdata;
  logic                  st_fault;
  logic [LANE_W-1:0]     ld_lane;
  mem_size_e             ld_size;
  logic                  ld_zext;
  logic                  ld_we;
  logic [DATAW-1:0]      ld_data;
  logic                  resp_take;

  // Pack the port-level request so the aligner sees one record.
  always_comb begin
    in_req       = '0;
    in_req.addr  = req_addr_i;
    in_req.we    = req_we_i;
    in_req.size  = mem_size_e'(req_size_i);
    in_req.zext  = req_unsigned_i;
    in_req.wdata = req_wdata_i;
  end

  mem_align #(
    .SIZE (SIZE)
  ) u_align (
    .req     (in_req),
    .mask    (st_mask),
    .wdata   (st_wdata),
    .fault   (st_fault),
    .ld_lane (ld_lane),
    .ld_size (ld_size),
    .ld_zext (ld_zext),
    .ld_raw  (mem_data_i),
    .ld_data (ld_data)
  );

  // Only IDLE can take a request; the RESP cycle is deliberately excluded.
  assign req_ready_o = (state == ST_IDLE);

  // A RAM response only matters while a strobe is outstanding.
  assign resp_take = ((state == ST_ISSUE) || (state == ST_WAIT)) && mem_resp_i;

  // Sequencer: registers the request, drives the one-cycle RAM strobe and
  // holds the response until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      ld_lane     <= '0;
      ld_size     <= MEM_BYTE;
      ld_zext     <= 1'b0;
      ld_we       <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_mask_o  <= '0;
      mem_data_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            ld_lane <= req_addr_i[LANE_W-1:0];
            ld_size <= mem_size_e'(req_size_i);
            ld_zext <= req_unsigned_i;
            ld_we   <= req_we_i;
            if (st_fault) begin
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              state       <= ST_RESP;
            end else begin
              mem_valid_o <= 1'b1;
              mem_we_o    <= req_we_i;
              mem_addr_o  <= {req_addr_i[MEM_ADDRW-1:LANE_W], {LANE_W{1'b0}}};
              mem_mask_o  <= st_mask;
              mem_data_o  <= st_wdata;
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE, ST_WAIT: begin
          mem_valid_o <= 1'b0;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= '0;
          mem_mask_o  <= '0;
          mem_data_o  <= '0;
          if (resp_take) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= ld_we ? '0 : ld_data;
            state       <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spram_req_adapter.sv
// Self-checking bench for spram_req_adapter: a word RAM with selectable
// pipelined/combinational response, a byte-array reference model, a
// directed vector table, reset/latency sequences and randomized traffic.
module tb_spram_req_adapter;

  localparam int SIZE      = 1024;
  localparam int DATAW     = 32;
  localparam int MEM_ADDRW = $clog2(SIZE);

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [31:0]          req_addr_i;
  logic                 req_we_i;
  logic [1:0]           req_size_i;
  logic                 req_unsigned_i;
  logic [31:0]          req_wdata_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [31:0]          rsp_rdata_o;
  logic                 rsp_err_o;
  logic [MEM_ADDRW-1:0] mem_addr_o;
  logic [31:0]          mem_data_o;
  logic [3:0]           mem_mask_o;
  logic                 mem_we_o;
  logic                 mem_valid_o;
  logic [31:0]          mem_data_i;
  logic                 mem_resp_i;

  int checks = 0;
  int errors = 0;

  spram_req_adapter #(
    .SIZE (SIZE), .DATAW (DATAW), .MEM_ADDRW (MEM_ADDRW)
  ) dut (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .req_valid_i (req_valid_i), .req_ready_o (req_ready_o),
    .req_addr_i (req_addr_i), .req_we_i (req_we_i),
    .req_size_i (req_size_i), .req_unsigned_i (req_unsigned_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o), .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o), .rsp_err_o (rsp_err_o),
    .mem_addr_o (mem_addr_o), .mem_data_o (mem_data_o),
    .mem_mask_o (mem_mask_o), .mem_we_o (mem_we_o),
    .mem_valid_o (mem_valid_o), .mem_data_i (mem_data_i),
    .mem_resp_i (mem_resp_i)
  );

  always #5 clk_i = ~clk_i;

  // Attached RAM: word array with byte mask; response either in the strobe
  // cycle (combinational) or ram_lat cycles after it (pipelined).
  bit          comb_mode = 1'b0;
  int          ram_lat = 1;
  int          cnt = 0;
  bit [31:0]   ram [SIZE/4];
  logic [31:0] rd_q = '0;
  logic [31:0] ram_w;
  logic [MEM_ADDRW-3:0] idx;

  assign idx        = mem_addr_o[MEM_ADDRW-1:2];
  assign mem_resp_i = comb_mode ? mem_valid_o : (cnt == 1);
  assign mem_data_i = comb_mode ? ram[idx] : rd_q;

  always @(posedge clk_i) begin
    if (mem_valid_o) begin
      ram_w = ram[idx];
      rd_q <= ram_w;
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask_o[b]) ram_w[8*b +: 8] = mem_data_o[8*b +: 8];
        ram[idx] <= ram_w;
      end
      cnt <= comb_mode ? 0 : ram_lat;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  // Reference model: memory as plain bytes, little endian.
  byte unsigned mdl [SIZE];

  function automatic bit modelFault(logic [31:0] a, logic [1:0] s);
    int n;
    if (s == 2'd3) return 1'b1;
    n = 1 << s;
    if ((a % 32'(n)) != 0) return 1'b1;
    if (a >= 32'(SIZE)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] modelLoad(logic [31:0] a, logic [1:0] s, logic uns);
    int n;
    logic [31:0] v;
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void modelStore(logic [31:0] a, logic [1:0] s, logic [31:0] wd);
    for (int i = 0; i < (1 << s); i++) mdl[int'(a) + i] = wd[8*i +: 8];
  endfunction

  function automatic void modelLanes(input logic [31:0] a, input logic [1:0] s,
                                     input logic [31:0] wd, output logic [3:0] m,
                                     output logic [31:0] d, output logic [31:0] dm);
    int lane;
    m = '0; d = '0; dm = '0;
    for (int i = 0; i < (1 << s); i++) begin
      lane = (int'(a) + i) % 4;
      m[lane] = 1'b1;
      d[8*lane +: 8] = wd[8*i +: 8];
      dm[8*lane +: 8] = 8'hFF;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction, called at a negedge with the DUT idle; returns at
  // the negedge after the response handshake.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input logic we,
                               input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                               input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input logic [3:0] exp_mask,
                               input logic [31:0] exp_mdata, input logic [31:0] dmask);
    int n;
    int lat;
    bit seen;
    logic [3:0] cm;
    logic [31:0] cd;
    logic [31:0] ca;
    logic cw;
    seen = 1'b0; cm = '0; cd = '0; ca = '0; cw = 1'b0;
    req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we; req_size_i = size;
    req_unsigned_i = uns; req_wdata_i = wdata; rsp_ready_i = 1'b0;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput({name, ".accept"}, 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 20) begin
      if (mem_valid_o) begin
        seen = 1'b1; cm = mem_mask_o; cd = mem_data_o; ca = 32'(mem_addr_o); cw = mem_we_o;
      end
      @(negedge clk_i);
      lat++;
    end
    if (mem_valid_o) seen = 1'b1;
    checkOutput({name, ".latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, ".rdata"}, rsp_rdata_o, exp_rdata);
    checkOutput({name, ".err"}, 32'(rsp_err_o), 32'(exp_err));
    checkOutput({name, ".mem_strobe"}, 32'(seen), 32'(!exp_err));
    if (!exp_err) begin
      checkOutput({name, ".mem_we"}, 32'(cw), 32'(we));
      checkOutput({name, ".mem_addr"}, ca, addr & 32'(SIZE - 4));
      if (we) begin
        checkOutput({name, ".mem_mask"}, 32'(cm), 32'(exp_mask));
        checkOutput({name, ".mem_data"}, cd & dmask, exp_mdata & dmask);
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      checkOutput({name, ".hold_valid"}, 32'(rsp_valid_o), 32'd1);
      checkOutput({name, ".hold_rdata"}, rsp_rdata_o, exp_rdata);
      checkOutput({name, ".hold_err"}, 32'(rsp_err_o), 32'(exp_err));
      checkOutput({name, ".hold_ready"}, 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    checkOutput({name, ".ready_after"}, 32'(req_ready_o), 32'd1);
    checkOutput({name, ".valid_after"}, 32'(rsp_valid_o), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic [31:0] emd;
    logic [31:0] edm;
    logic [3:0]  em;
    logic [1:0]  sz;
    logic        we;
    logic        uns;
    logic        f;
    int          r;

    vecs[0]  = '{"st_word",   32'h010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0, 32'h0,        1'b0, 3, 4'hF, 32'hDEADBEEF};
    vecs[1]  = '{"ld_word",   32'h010, 1'b0, 2'd2, 1'b0, 32'h0,        5, 32'hDEADBEEF, 1'b0, 3, 4'h0, 32'h0};
    vecs[2]  = '{"st_byte",   32'h013, 1'b1, 2'd0, 1'b0, 32'h00000080, 0, 32'h0,        1'b0, 3, 4'h8, 32'h80808080};
    vecs[3]  = '{"ld_byte_s", 32'h013, 1'b0, 2'd0, 1'b0, 32'h0,        0, 32'hFFFFFF80, 1'b0, 3, 4'h0, 32'h0};
    vecs[4]  = '{"ld_byte_u", 32'h013, 1'b0, 2'd0, 1'b1, 32'h0,        0, 32'h00000080, 1'b0, 3, 4'h0, 32'h0};
    vecs[5]  = '{"st_word2",  32'h010, 1'b1, 2'd2, 1'b0, 32'h80011234, 0, 32'h0,        1'b0, 3, 4'hF, 32'h80011234};
    vecs[6]  = '{"ld_half_s", 32'h012, 1'b0, 2'd1, 1'b0, 32'h0,        0, 32'hFFFF8001, 1'b0, 3, 4'h0, 32'h0};
    vecs[7]  = '{"ld_half_u", 32'h012, 1'b0, 2'd1, 1'b1, 32'h0,        0, 32'h00008001, 1'b0, 3, 4'h0, 32'h0};
    vecs[8]  = '{"ld_half_mis", 32'h011, 1'b0, 2'd1, 1'b0, 32'h0,      0, 32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[9]  = '{"ld_oor",    32'h400, 1'b0, 2'd2, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1, 4'h0, 32'h0};
    vecs[10] = '{"ld_rsvd",   32'h020, 1'b0, 2'd3, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1, 4'h0, 32'h0};

    rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
    req_size_i = '0; req_unsigned_i = 1'b0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    #1;
    checkOutput("rst.req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rst.rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst.rsp_rdata", rsp_rdata_o, 32'd0);
    checkOutput("rst.rsp_err", 32'(rsp_err_o), 32'd0);
    checkOutput("rst.mem_valid", 32'(mem_valid_o), 32'd0);
    checkOutput("rst.mem_bus", {mem_data_o ^ 32'(mem_addr_o)}, 32'd0);
    checkOutput("rst.mem_ctl", 32'({mem_mask_o, mem_we_o}), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed vectors against the pipelined RAM.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].name, vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].uns,
                    vecs[i].wdata, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err,
                    vecs[i].exp_lat, vecs[i].exp_mask, vecs[i].exp_mdata, 32'hFFFF_FFFF);
      if (vecs[i].we && !vecs[i].exp_err) modelStore(vecs[i].addr, vecs[i].size, vecs[i].wdata);
    end

    // Combinational RAM answers in the strobe cycle.
    comb_mode = 1'b1;
    applyStimulus("comb_ld_word", 32'h010, 1'b0, 2'd2, 1'b0, 32'h0, 0, 32'h80011234,
                  1'b0, 2, 4'h0, 32'h0, 32'h0);
    comb_mode = 1'b0;

    // Reset while waiting on a slow RAM; its late response must be ignored.
    ram_lat = 4;
    req_valid_i = 1'b1; req_addr_i = 32'h010; req_we_i = 1'b0; req_size_i = 2'd2;
    req_unsigned_i = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checkOutput("rstw.issue_strobe", 32'(mem_valid_o), 32'd1);
    @(negedge clk_i);
    checkOutput("rstw.wait_busy", 32'({req_ready_o, rsp_valid_o, mem_valid_o}), 32'd0);
    #1 rst_ni = 1'b0;
    #1;
    checkOutput("rstw.req_ready", 32'(req_ready_o), 32'd1);
    checkOutput("rstw.rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rstw.mem_valid", 32'(mem_valid_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("rstw.late_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rstw.late_req_ready", 32'(req_ready_o), 32'd1);
    end
    ram_lat = 1;

    // Randomized traffic against the byte-level model.
    for (int t = 0; t < 150; t++) begin
      comb_mode = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'(SIZE) + $urandom_range(0, 255);
      else if (r == 1) a = $urandom;
      else if (r < 6) a = $urandom_range(0, 127);
      else a = $urandom_range(0, SIZE - 1);
      if (sz != 2'd3 && $urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      f   = modelFault(a, sz);
      er  = (f || we) ? 32'h0 : modelLoad(a, sz, uns);
      modelLanes(a, sz, wd, em, emd, edm);
      applyStimulus($sformatf("rnd%0d", t), a, we, sz, uns, wd, $urandom_range(0, 2), er, f,
                    f ? 1 : (comb_mode ? 2 : 3), em, emd, edm);
      if (we && !f) modelStore(a, sz, wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
